// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback per
// instruction, stalls on a req/ready memory handshake, parks in a sticky HALT state,
// flags unknown opcodes and counts retired instructions (saturating).
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned CNT_W    = 32,
    parameter logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000,
    parameter logic [OPCODE_W-1:0] OP_LW    = 6'b100011,
    parameter logic [OPCODE_W-1:0] OP_SW    = 6'b101011,
    parameter logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100,
    parameter logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000,
    parameter logic [OPCODE_W-1:0] OP_J     = 6'b000010,
    parameter logic [OPCODE_W-1:0] OP_HALT  = 6'b111111
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pcWrite,
    output logic                pcWriteCond,
    output logic [1:0]          pcSource,
    output logic                iorD,
    output logic                memRead,
    output logic                memWrite,
    output logic                irWrite,
    output logic                memtoReg,
    output logic                regDest,
    output logic                regWrite,
    output logic                alu_srcA,
    output logic [1:0]          alu_srcB,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    localparam logic [ALUOP_W-1:0] AluAdd   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] AluSub   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] AluFunct = ALUOP_W'(2);

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StMemAdr, StMemRd, StWbMem, StMemWr,
        StExecR, StWbR, StExecI, StWbI, StBranch, StJump, StHalt
    } state_e;

    state_e           state_q, state_d;
    logic             is_store_q;
    logic             op_known;
    logic             retire;
    logic [CNT_W-1:0] count_q;

    assign op_known = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J) ||
                      (opcode == OP_HALT);

    // An instruction retires on its final transition back into FETCH.
    assign retire = (state_d == StFetch) &&
                    (state_q == StWbMem || state_q == StMemWr || state_q == StWbR ||
                     state_q == StWbI || state_q == StBranch || state_q == StJump);

    assign instr_count = count_q;

    // State register; lw/sw choice is captured in DECODE since opcode is only valid there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                is_store_q <= (opcode == OP_SW);
            end
        end
    end

    // Saturating retired-instruction counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (retire && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Next-state logic; unencoded states fall back to FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExecR;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StExecI;
                    OP_J:         state_d = StJump;
                    OP_HALT:      state_d = StHalt;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = is_store_q ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) state_d = StWbMem;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExecR:  state_d = StWbR;
            StExecI:  state_d = StWbI;
            StWbMem, StWbR, StWbI, StBranch, StJump: state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    // Datapath controls decoded from state; fetch-side PC/IR loads wait for mem_ready.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        pcSource    = 2'd0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memtoReg    = 1'b0;
        regDest     = 1'b0;
        regWrite    = 1'b0;
        alu_srcA    = 1'b0;
        alu_srcB    = 2'd0;
        alu_op      = AluAdd;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            StFetch: begin
                memRead  = 1'b1;
                alu_srcB = 2'd1;
                pcWrite  = mem_ready;
                irWrite  = mem_ready;
            end
            StDecode: begin
                alu_srcB = 2'd3;
                illegal  = !op_known;
            end
            StMemAdr, StExecI: begin
                alu_srcA = 1'b1;
                alu_srcB = 2'd2;
            end
            StMemRd: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            StWbMem: begin
                regWrite = 1'b1;
                memtoReg = 1'b1;
            end
            StMemWr: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            StExecR: begin
                alu_srcA = 1'b1;
                alu_op   = AluFunct;
            end
            StWbR: begin
                regWrite = 1'b1;
                regDest  = 1'b1;
            end
            StWbI:    regWrite = 1'b1;
            StBranch: begin
                alu_srcA    = 1'b1;
                alu_op      = AluSub;
                pcWriteCond = 1'b1;
                pcSource    = 2'd1;
            end
            StJump: begin
                pcWrite  = 1'b1;
                pcSource = 2'd2;
            end
            StHalt:   halted = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (built with a 4-bit counter so saturation
// is reachable). Each step pushes the expected outputs/count and pops them at negedge.
module tb_multicycle_control_unit;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] OP_BAD   = 6'b010101;

    typedef enum logic [3:0] {
        PIdle, PFetch, PDecode, PMemAdr, PMemRd, PWbMem, PMemWr,
        PExecR, PWbR, PExecI, PWbI, PBranch, PJump, PHalt
    } phase_t;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] pcSource;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDest;
        logic       regWrite;
        logic       alu_srcA;
        logic [1:0] alu_srcB;
        logic [1:0] alu_op;
        logic       halted;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        phase_t     ph;
        outs_t      o;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memtoReg, regDest, regWrite, alu_srcA, halted, illegal;
    logic [1:0] pcSource, alu_srcB, alu_op;
    logic [3:0] instr_count;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_cnt = '0;
    exp_t       sb_q[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSource(pcSource), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .memtoReg(memtoReg),
        .regDest(regDest), .regWrite(regWrite), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
        .alu_op(alu_op), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    function automatic logic op_legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ ||
               op == OP_ADDI || op == OP_J || op == OP_HALT;
    endfunction

    // Reference control table for each phase.
    function automatic outs_t exp_outs(input phase_t p, input logic mr, input logic [5:0] op);
        outs_t e = '0;
        case (p)
            PFetch:  begin e.memRead = 1; e.alu_srcB = 2'd1; e.pcWrite = mr; e.irWrite = mr; end
            PDecode: begin e.alu_srcB = 2'd3; e.illegal = !op_legal(op); end
            PMemAdr: begin e.alu_srcA = 1; e.alu_srcB = 2'd2; end
            PMemRd:  begin e.memRead = 1; e.iorD = 1; end
            PWbMem:  begin e.regWrite = 1; e.memtoReg = 1; end
            PMemWr:  begin e.memWrite = 1; e.iorD = 1; end
            PExecR:  begin e.alu_srcA = 1; e.alu_op = 2'd2; end
            PWbR:    begin e.regWrite = 1; e.regDest = 1; end
            PExecI:  begin e.alu_srcA = 1; e.alu_srcB = 2'd2; end
            PWbI:    e.regWrite = 1;
            PBranch: begin e.alu_srcA = 1; e.alu_op = 2'd1; e.pcWriteCond = 1; e.pcSource = 2'd1; end
            PJump:   begin e.pcWrite = 1; e.pcSource = 2'd2; end
            PHalt:   e.halted = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic push_exp(input phase_t p, input logic mr, input logic [5:0] op);
        exp_t e;
        e.ph  = p;
        e.o   = exp_outs(p, mr, op);
        e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t  e;
        outs_t obs;
        e   = sb_q.pop_front();
        obs = '{pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite, memtoReg,
                regDest, regWrite, alu_srcA, alu_srcB, alu_op, halted, illegal};
        checks++;
        assert (obs === e.o) else begin
            failures++;
            $error("FAIL outs[%s] got=%h expected=%h", e.ph.name(), obs, e.o);
        end
        checks++;
        assert (instr_count === e.cnt) else begin
            failures++;
            $error("FAIL instr_count[%s] got=%0d expected=%0d", e.ph.name(), instr_count, e.cnt);
        end
    endtask

    // One clock cycle in the given phase; called #1 after a rising edge.
    task automatic step(input phase_t p, input logic mr, input logic [5:0] op);
        mem_ready = mr;
        opcode    = op;
        push_exp(p, mr, op);
        @(negedge clk);
        pop_check();
        if ((p == PWbMem || p == PWbR || p == PWbI || p == PBranch || p == PJump ||
             (p == PMemWr && mr)) && exp_cnt != 4'hF)
            exp_cnt = exp_cnt + 4'd1;
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle: outputs must clear without waiting for a clock.
    task automatic async_reset_and_release();
        reset_n = 1'b0;
        exp_cnt = '0;
        push_exp(PIdle, mem_ready, opcode);
        #1;
        pop_check();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(PIdle, 1'b1, OP_RTYPE);
    endtask

    task automatic run_rtype();
        step(PFetch, 1'b1, OP_RTYPE);
        step(PDecode, 1'b1, OP_RTYPE);
        step(PExecR, 1'b1, OP_RTYPE);
        step(PWbR, 1'b1, OP_RTYPE);
    endtask

    initial begin
        #2;
        // 1: reset, then an R-type.
        async_reset_and_release();
        run_rtype();
        // 2: lw with three stalled MEM_RD cycles.
        step(PFetch, 1'b1, OP_LW);
        step(PDecode, 1'b1, OP_LW);
        step(PMemAdr, 1'b1, 6'b000000);
        for (int i = 0; i < 3; i++) step(PMemRd, 1'b0, 6'b000000);
        step(PMemRd, 1'b1, 6'b000000);
        step(PWbMem, 1'b1, 6'b000000);
        // Fetch stall, then addi.
        step(PFetch, 1'b0, OP_ADDI);
        step(PFetch, 1'b1, OP_ADDI);
        step(PDecode, 1'b1, OP_ADDI);
        step(PExecI, 1'b0, OP_ADDI);
        step(PWbI, 1'b1, OP_ADDI);
        // 3: beq then j.
        step(PFetch, 1'b1, OP_BEQ);
        step(PDecode, 1'b1, OP_BEQ);
        step(PBranch, 1'b1, OP_BEQ);
        step(PFetch, 1'b1, OP_J);
        step(PDecode, 1'b1, OP_J);
        step(PJump, 1'b1, OP_J);
        // 4: illegal opcode, not counted.
        step(PFetch, 1'b1, OP_BAD);
        step(PDecode, 1'b1, OP_BAD);
        step(PFetch, 1'b0, OP_BAD);
        step(PFetch, 1'b1, OP_HALT);
        // 5: halt is sticky regardless of inputs.
        step(PDecode, 1'b1, OP_HALT);
        for (int i = 0; i < 100; i++) step(PHalt, 1'(i % 2), 6'($urandom));
        async_reset_and_release();
        // 6: counter saturation, then reset during a stalled store.
        for (int i = 0; i < 20; i++) run_rtype();
        step(PFetch, 1'b1, OP_SW);
        step(PDecode, 1'b1, OP_SW);
        step(PMemAdr, 1'b1, 6'b000000);
        step(PMemWr, 1'b0, 6'b000000);
        mem_ready = 1'b0;
        async_reset_and_release();
        run_rtype();
        step(PFetch, 1'b0, OP_RTYPE);
        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
